// File: rtl/mac_pkg.sv
// Shared definitions for the MAC result path: data/address/dimension widths,
// the packed dimension-word layout and the result reader state encoding.
package mac_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 12;
   localparam int DIM_W  = 16;

   // Dimension word layout: {rows, cols}
   localparam int DIM_ROWS_LSB = 16;
   localparam int DIM_COLS_LSB = 0;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } rd_state_t;

   function automatic logic [2*DIM_W-1:0] dim_word(input logic [DIM_W-1:0] rows,
                                                   input logic [DIM_W-1:0] cols);
      return {rows, cols};
   endfunction

endpackage

// File: rtl/result_sram_reader_if.sv
// Job request, result SRAM read port and element stream of the result reader.
// The master modport is the reader's view; slave is the surrounding system's view.
interface result_sram_reader_if;
   import mac_pkg::*;

   logic              start_valid;
   logic              start_ready;
   logic [ADDR_W-1:0] base_addr;
   logic [DIM_W-1:0]  num_rows;
   logic [DIM_W-1:0]  num_cols;
   logic [ADDR_W-1:0] sram_result_read_address;
   logic [DATA_W-1:0] sram_result_read_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [DIM_W-1:0]  out_row;
   logic [DIM_W-1:0]  out_col;
   logic              out_last;
   logic              busy;
   logic              done;

   modport master (
      input  start_valid, base_addr, num_rows, num_cols, sram_result_read_data, out_ready,
      output start_ready, sram_result_read_address, out_valid, out_data, out_row, out_col,
             out_last, busy, done
   );

   modport slave (
      output start_valid, base_addr, num_rows, num_cols, sram_result_read_data, out_ready,
      input  start_ready, sram_result_read_address, out_valid, out_data, out_row, out_col,
             out_last, busy, done
   );

endinterface

// File: rtl/result_rd_fifo.sv
// Prefetch FIFO holding returned result elements with their tags.
// The head entry is presented combinationally and holds until popped.
module result_rd_fifo #(
   parameter  int WIDTH = 65,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_data = mem[rd_ptr];

   // Storage is cleared on reset so the visible head reads as zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/result_sram_reader.sv
// Streams a result matrix out of result SRAM as tagged elements, hiding the
// one-cycle read latency behind a credit-controlled prefetch FIFO.
//
// state | meaning
// IDLE  | waiting for a job, start_ready high
// READ  | issuing reads while FIFO credit is available
// DRAIN | all reads issued, waiting for the FIFO to empty
// DONE  | one-cycle done pulse, then back to IDLE
module result_sram_reader
   import mac_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input logic                  clk,
   input logic                  reset,
   result_sram_reader_if.master bus
);

   localparam int ENTRY_W = DATA_W + 2*DIM_W + 1;
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int IDX_W   = 2*DIM_W;

   rd_state_t         state;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] addr_hold;
   logic [ADDR_W-1:0] issue_addr;
   logic [DIM_W-1:0]  cols_q;
   logic [DIM_W-1:0]  row_q;
   logic [DIM_W-1:0]  col_q;
   logic [DIM_W-1:0]  pend_row;
   logic [DIM_W-1:0]  pend_col;
   logic              pend_last;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  total_q;
   logic [IDX_W-1:0]  total_start;
   logic              inflight;
   logic              issue;
   logic              issue_last;
   logic              start_hs;
   logic              pop;
   logic              start_ready_q;
   logic              busy_q;
   logic              done_q;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W:0]    credit_used;
   logic [CNT_W:0]    count_next;
   logic [ENTRY_W-1:0] push_entry;
   logic [ENTRY_W-1:0] head_entry;

   assign total_start = IDX_W'(bus.num_rows) * IDX_W'(bus.num_cols);
   assign start_hs    = bus.start_valid && start_ready_q;
   assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
   assign issue       = (state == READ) && !fifo_full &&
                        (credit_used < (CNT_W+1)'(FIFO_DEPTH));
   assign issue_last  = (idx_q == total_q - 1'b1);
   assign issue_addr  = base_q + idx_q[ADDR_W-1:0];
   assign pop         = bus.out_valid && bus.out_ready;
   assign count_next  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};

   // Address is live during the issue cycle so data lands one cycle later.
   assign bus.sram_result_read_address = issue ? issue_addr : addr_hold;

   assign push_entry = {bus.sram_result_read_data, pend_row, pend_col, pend_last};
   assign {bus.out_data, bus.out_row, bus.out_col, bus.out_last} = head_entry;
   assign bus.out_valid   = !fifo_empty;
   assign bus.start_ready = start_ready_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         start_ready_q <= 1'b1;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         base_q        <= '0;
         addr_hold     <= '0;
         cols_q        <= '0;
         row_q         <= '0;
         col_q         <= '0;
         idx_q         <= '0;
         total_q       <= '0;
         inflight      <= 1'b0;
         pend_row      <= '0;
         pend_col      <= '0;
         pend_last     <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            addr_hold <= issue_addr;
            pend_row  <= row_q;
            pend_col  <= col_q;
            pend_last <= issue_last;
            idx_q     <= idx_q + 1'b1;
            if (col_q == cols_q - 1'b1) begin
               col_q <= '0;
               row_q <= row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
         end
         case (state)
            IDLE: if (start_hs) begin
               base_q        <= bus.base_addr;
               cols_q        <= bus.num_cols;
               total_q       <= total_start;
               idx_q         <= '0;
               row_q         <= '0;
               col_q         <= '0;
               start_ready_q <= 1'b0;
               if (total_start == '0) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end else begin
                  state  <= READ;
                  busy_q <= 1'b1;
               end
            end
            READ: if (issue && issue_last) state <= DRAIN;
            // Finish on the edge that pops the final element.
            DRAIN: if (!inflight && count_next == '0) begin
               state  <= DONE;
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
            DONE: begin
               state         <= IDLE;
               done_q        <= 1'b0;
               start_ready_q <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   result_rd_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (inflight),
      .push_data (push_entry),
      .pop       (pop),
      .head_data (head_entry),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_result_sram_reader.sv
// Bench for result_sram_reader: SRAM model with random contents, directed and
// random jobs compared against an index-arithmetic model of the element stream.
module tb_result_sram_reader;
   import mac_pkg::*;

   logic clk = 1'b0;
   logic reset;

   result_sram_reader_if bus();

   result_sram_reader #(.FIFO_DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [DATA_W-1:0] mem [0:4095];

   always @(posedge clk) bus.sram_result_read_data <= mem[bus.sram_result_read_address];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_job(input logic [11:0] base, input int rows, input int cols,
                          input bit rnd_ready, input bit check_addr);
      int total, n, cyc, budget, er, ec;
      logic [11:0] prev_addr, ea;
      bit pv, pr, rdy;
      logic [DATA_W-1:0] sd;
      logic [15:0] sr, sc;
      logic sl;
      total = rows * cols;
      @(negedge clk);
      prev_addr = bus.sram_result_read_address;
      chk("start_ready_idle", bus.start_ready, 1);
      bus.start_valid = 1'b1;
      bus.base_addr   = base;
      bus.num_rows    = 16'(rows);
      bus.num_cols    = 16'(cols);
      bus.out_ready   = 1'b1;
      @(posedge clk);
      #1;
      bus.start_valid = 1'b0;
      bus.base_addr   = 12'($urandom);
      bus.num_rows    = 16'($urandom);
      bus.num_cols    = 16'($urandom);
      if (total == 0) begin
         @(negedge clk);
         chk("zero_done", bus.done, 1);
         chk("zero_addr", bus.sram_result_read_address, prev_addr);
         chk("zero_valid", bus.out_valid, 0);
         chk("zero_busy", bus.busy, 0);
         @(negedge clk);
         chk("zero_done_clr", bus.done, 0);
         chk("zero_start_ready", bus.start_ready, 1);
         chk("zero_valid2", bus.out_valid, 0);
         chk("zero_addr2", bus.sram_result_read_address, prev_addr);
         return;
      end
      n = 0; cyc = 0; budget = total * 20 + 20; pv = 0; pr = 0;
      sd = '0; sr = '0; sc = '0; sl = 1'b0;
      while (n < total && cyc < budget) begin
         @(negedge clk);
         chk("busy", bus.busy, 1);
         chk("done_early", bus.done, 0);
         chk("credit", (int'(dut.fifo_count) + int'(dut.inflight) <= 4), 1);
         if (check_addr) begin
            if (cyc < total) chk("addr", bus.sram_result_read_address, 12'(base + cyc));
            else             chk("addr_hold", bus.sram_result_read_address, 12'(base + total - 1));
            if (cyc < 2)       chk("latency_empty", bus.out_valid, 0);
            else if (cyc == 2) chk("latency_valid", bus.out_valid, 1);
         end
         if (pv && !pr) begin
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_data", bus.out_data, sd);
            chk("stall_row", bus.out_row, sr);
            chk("stall_col", bus.out_col, sc);
            chk("stall_last", bus.out_last, sl);
         end
         if (bus.out_valid) begin
            ea = 12'(base + n);
            er = n / cols;
            ec = n % cols;
            chk("out_data", bus.out_data, mem[ea]);
            chk("out_row", bus.out_row, 16'(er));
            chk("out_col", bus.out_col, 16'(ec));
            chk("out_last", bus.out_last, (n == total - 1));
         end
         rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.out_ready = rdy;
         pv = bus.out_valid; pr = rdy;
         sd = bus.out_data; sr = bus.out_row; sc = bus.out_col; sl = bus.out_last;
         if (bus.out_valid && rdy) n++;
         cyc++;
      end
      chk("job_timeout", (n == total), 1);
      @(negedge clk);
      chk("done_pulse", bus.done, 1);
      chk("drain_empty", bus.out_valid, 0);
      chk("done_busy", bus.busy, 0);
      chk("done_start_ready", bus.start_ready, 0);
      @(negedge clk);
      chk("done_clr", bus.done, 0);
      chk("idle_start_ready", bus.start_ready, 1);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = $urandom;
      bus.start_valid = 1'b0;
      bus.base_addr   = '0;
      bus.num_rows    = '0;
      bus.num_cols    = '0;
      bus.out_ready   = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_start_ready", bus.start_ready, 1);
      chk("rst_addr", bus.sram_result_read_address, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_data", bus.out_data, 0);
      chk("rst_row", bus.out_row, 0);
      chk("rst_col", bus.out_col, 0);
      chk("rst_last", bus.out_last, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      reset = 1'b0;

      run_job(12'd5, 2, 3, 1'b0, 1'b1);
      run_job(12'd5, 2, 3, 1'b1, 1'b0);
      run_job(12'd77, 0, 7, 1'b0, 1'b0);
      run_job(12'h3FF, 1, 1, 1'b0, 1'b1);
      run_job(12'd4094, 1, 4, 1'b0, 1'b1);

      // Reset in the middle of a stalled 4x4 job
      @(negedge clk);
      bus.start_valid = 1'b1;
      bus.base_addr   = 12'd100;
      bus.num_rows    = 16'd4;
      bus.num_cols    = 16'd4;
      bus.out_ready   = 1'b0;
      @(posedge clk);
      #1 bus.start_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_reset_valid", bus.out_valid, 1);
      chk("pre_reset_busy", bus.busy, 1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_start_ready", bus.start_ready, 1);
      chk("mid_rst_addr", bus.sram_result_read_address, 0);
      chk("mid_rst_valid", bus.out_valid, 0);
      chk("mid_rst_data", bus.out_data, 0);
      chk("mid_rst_row", bus.out_row, 0);
      chk("mid_rst_col", bus.out_col, 0);
      chk("mid_rst_last", bus.out_last, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_done", bus.done, 0);
      chk("mid_rst_fifo_empty", dut.u_fifo.empty, 1);
      chk("mid_rst_inflight", dut.inflight, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_no_done", bus.done, 0);
      run_job(12'd200, 2, 2, 1'b0, 1'b1);

      for (int j = 0; j < 4; j++)
         run_job(12'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(1, 5)), 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
